fifo_packer_n: RTL



---
 rtl/fifo_packer_pkg.sv | 22 ++
 rtl/fifo_packer_mask.sv | 37 +++
 rtl/fifo_packer_n.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_packer_pkg.sv
// Shared types and sizing helpers for the word packer and its companion blocks.
package fifo_packer_pkg;

    localparam int unsigned C_WORD_WIDTH = 32;

    typedef logic [C_WORD_WIDTH-1:0] word_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // The packing buffer holds up to 2*words-1 words, so its count needs clog2(2*words) bits.
    function automatic int unsigned cnt_width(input int unsigned words);
        return clog2(2 * words);
    endfunction

endpackage

// File: rtl/fifo_packer_mask.sv
// Registered enable-to-word mask: words at index >= en are zeroed, en is passed alongside.
module fifo_packer_mask
    import fifo_packer_pkg::*;
#(
    parameter int unsigned C_WORDS    = 4,
    parameter int unsigned C_EN_WIDTH = clog2(C_WORDS) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_WORDS*C_WORD_WIDTH-1:0]   data,
    input  logic [C_EN_WIDTH-1:0]             en,
    output logic [C_WORDS*C_WORD_WIDTH-1:0]   masked,
    output logic [C_EN_WIDTH-1:0]             masked_en
);

    logic [C_WORDS*C_WORD_WIDTH-1:0] keep;

    always_comb begin
        keep = '0;
        for (int unsigned i = 0; i < C_WORDS; i++) begin
            word_t w;
            w = data[i*C_WORD_WIDTH +: C_WORD_WIDTH];
            keep[i*C_WORD_WIDTH +: C_WORD_WIDTH] = (C_EN_WIDTH'(i) < en) ? w : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            masked    <= '0;
            masked_en <= '0;
        end else begin
            masked    <= keep;
            masked_en <= en;
        end
    end

endmodule

// File: rtl/fifo_packer_n.sv
// Packs 0..C_WORDS 32-bit words per cycle into full C_WORDS-wide FIFO writes with a word count.
// Optional FIFO_PACKER_WORD_COUNT_EN adds a saturating PACKED_WORD_COUNT output.
module fifo_packer_n
    import fifo_packer_pkg::*;
#(
    parameter int unsigned C_WORDS    = 4,
    parameter int unsigned C_EN_WIDTH = clog2(C_WORDS) + 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [C_WORDS*C_WORD_WIDTH-1:0]  DATA_IN,
    input  logic [C_EN_WIDTH-1:0]            DATA_IN_EN,
    input  logic                             DATA_IN_DONE,
    input  logic                             DATA_IN_ERR,
    input  logic                             DATA_IN_FLUSH,
    output logic [C_WORDS*C_WORD_WIDTH-1:0]  PACKED_DATA,
    output logic                             PACKED_WEN,
    output logic [C_EN_WIDTH-1:0]            PACKED_EN,
    output logic                             PACKED_DATA_DONE,
    output logic                             PACKED_DATA_ERR,
`ifdef FIFO_PACKER_WORD_COUNT_EN
    output logic [31:0]                      PACKED_WORD_COUNT,
`endif
    output logic                             PACKED_DATA_FLUSHED
);

    localparam int unsigned DW = C_WORDS * C_WORD_WIDTH;
    localparam int unsigned BW = (2 * C_WORDS - 1) * C_WORD_WIDTH;
    localparam int unsigned CW = cnt_width(C_WORDS);
    localparam logic [CW-1:0]         FULL    = CW'(C_WORDS);
    localparam logic [C_EN_WIDTH-1:0] FULL_EN = C_EN_WIDTH'(C_WORDS);

    logic [DW-1:0]         data_q;
    logic [C_EN_WIDTH-1:0] en_q;
    logic                  done_q, err_q, flush_q;
    logic [DW-1:0]         masked;
    logic [C_EN_WIDTH-1:0] masked_en;
    logic [BW-1:0]         buffer, buffer_next;
    logic [CW-1:0]         count, count_next, base;
    logic [C_EN_WIDTH-1:0] flush_en, flush_en_next;
    logic                  write;

    always_ff @(posedge CLK) begin
        data_q <= DATA_IN;
        if (RST) begin
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            en_q    <= (DATA_IN_EN > FULL_EN) ? FULL_EN : DATA_IN_EN;
            done_q  <= DATA_IN_DONE;
            err_q   <= DATA_IN_ERR;
            flush_q <= DATA_IN_FLUSH;
        end
    end

    fifo_packer_mask #(
        .C_WORDS    (C_WORDS),
        .C_EN_WIDTH (C_EN_WIDTH)
    ) u_mask (
        .clk       (CLK),
        .rst       (RST),
        .data      (data_q),
        .en        (en_q),
        .masked    (masked),
        .masked_en (masked_en)
    );

    // Words above count are always zero, so a forced flush write pads with zeros for free.
    always_comb begin
        write         = count >= FULL;
        base          = write ? count - FULL : count;
        buffer_next   = write ? (buffer >> DW) : buffer;
        count_next    = base;
        flush_en_next = write ? '0 : flush_en;
        if (masked_en != '0) begin
            buffer_next = buffer_next | ({{(BW-DW){1'b0}}, masked} << (base * C_WORD_WIDTH));
            count_next  = base + CW'(masked_en);
        end
        if (flush_q && count != '0 && count < FULL) begin
            count_next    = FULL;
            flush_en_next = C_EN_WIDTH'(count);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            buffer              <= '0;
            count               <= '0;
            flush_en            <= '0;
            PACKED_DATA         <= '0;
            PACKED_WEN          <= 1'b0;
            PACKED_EN           <= '0;
            PACKED_DATA_DONE    <= 1'b0;
            PACKED_DATA_ERR     <= 1'b0;
            PACKED_DATA_FLUSHED <= 1'b0;
        end else begin
            buffer              <= buffer_next;
            count               <= count_next;
            flush_en            <= flush_en_next;
            PACKED_DATA         <= buffer[DW-1:0];
            PACKED_WEN          <= write;
            PACKED_EN           <= write ? ((flush_en != '0) ? flush_en : FULL_EN) : '0;
            PACKED_DATA_DONE    <= done_q;
            PACKED_DATA_ERR     <= err_q;
            PACKED_DATA_FLUSHED <= flush_q;
        end
    end

`ifdef FIFO_PACKER_WORD_COUNT_EN
    logic [32:0] word_sum;

    always_comb begin
        word_sum = {1'b0, PACKED_WORD_COUNT} + 33'(PACKED_EN);
    end

    always_ff @(posedge CLK) begin
        if (RST || PACKED_DATA_FLUSHED) begin
            PACKED_WORD_COUNT <= '0;
        end else if (PACKED_WEN) begin
            PACKED_WORD_COUNT <= word_sum[32] ? '1 : word_sum[31:0];
        end
    end
`endif

endmodule
